// File: rtl/i2c_slave_word_port_pkg.sv
// Shared types and constants for the I2C word-port target.
package i2c_slave_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      RX_BYTE,
      RX_ACK,
      TX_BYTE,
      TX_ACK,
      IGNORE
   } state_t;

   localparam logic       RW_WRITE  = 1'b0;
   localparam logic       RW_READ   = 1'b1;
   localparam logic [7:0] IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/i2c_slave_word_port_if.sv
// Open-drain I2C bus lines as seen by the target.
interface i2c_slave_word_port_if;

   logic scl_i;
   logic sda_i;
   logic sda_o;
   logic sda_oen;

   modport slave  (input scl_i, sda_i, output sda_o, sda_oen);
   modport master (output scl_i, sda_i, input sda_o, sda_oen);

endinterface

// File: rtl/i2c_slave_word_port_line_filter.sv
// Synchronizer, level-hold glitch filter and edge detect for one I2C line.
module i2c_line_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic line,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

   logic          sync1;
   logic          sync2;
   logic          filt;
   logic          filt_d;
   logic [CW-1:0] cnt;

   // A new level is accepted only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         filt   <= 1'b1;
         filt_d <= 1'b1;
         cnt    <= '0;
      end else begin
         sync1  <= line;
         sync2  <= sync1;
         filt_d <= filt;
         if (sync2 == filt) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            filt <= sync2;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign level = filt;
   assign rise  = filt & ~filt_d;
   assign fall  = ~filt & filt_d;

endmodule

// File: rtl/i2c_slave_word_port.sv
// I2C target at a fixed address: 16-bit word writes (MSB byte first) and word reads.
module i2c_slave_word_port
   import i2c_slave_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h2C,
   parameter int         FILTER_LEN = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   i2c_slave_word_port_if.slave  bus,
   output logic [15:0]           wr_data,
   output logic                  wr_valid,
   input  logic [15:0]           rd_data,
   output logic                  rd_strobe,
   output logic                  busy
);

   logic scl, scl_rise, scl_fall;
   logic sda, sda_rise, sda_fall;
   logic start_cond, stop_cond;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
      .clk   (clk),
      .reset (reset),
      .line  (bus.scl_i),
      .level (scl),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
      .clk   (clk),
      .reset (reset),
      .line  (bus.sda_i),
      .level (sda),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   assign start_cond = sda_fall & scl;
   assign stop_cond  = sda_rise & scl;

   state_t      state, state_n;
   logic [3:0]  bit_cnt, bit_cnt_n;
   logic [7:0]  rx_sr, rx_sr_n;
   logic [7:0]  hi_byte, hi_byte_n;
   logic [1:0]  byte_idx, byte_idx_n;
   logic [23:0] tx_sr, tx_sr_n;
   logic        rw, rw_n;
   logic        oen, oen_n;
   logic [15:0] wr_data_n;
   logic        wr_valid_n, rd_strobe_n, busy_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         rx_sr     <= '0;
         hi_byte   <= '0;
         byte_idx  <= '0;
         tx_sr     <= '1;
         rw        <= RW_WRITE;
         oen       <= 1'b1;
         wr_data   <= '0;
         wr_valid  <= 1'b0;
         rd_strobe <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         rx_sr     <= rx_sr_n;
         hi_byte   <= hi_byte_n;
         byte_idx  <= byte_idx_n;
         tx_sr     <= tx_sr_n;
         rw        <= rw_n;
         oen       <= oen_n;
         wr_data   <= wr_data_n;
         wr_valid  <= wr_valid_n;
         rd_strobe <= rd_strobe_n;
         busy      <= busy_n;
      end
   end

   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      rx_sr_n     = rx_sr;
      hi_byte_n   = hi_byte;
      byte_idx_n  = byte_idx;
      tx_sr_n     = tx_sr;
      rw_n        = rw;
      oen_n       = oen;
      wr_data_n   = wr_data;
      wr_valid_n  = 1'b0;
      rd_strobe_n = 1'b0;
      busy_n      = busy;

      if (stop_cond) begin
         state_n = IDLE;
         oen_n   = 1'b1;
         busy_n  = 1'b0;
      end else if (start_cond) begin
         state_n   = ADDR;
         bit_cnt_n = '0;
         oen_n     = 1'b1;
      end else begin
         case (state)
            ADDR: begin
               if (scl_rise) begin
                  rx_sr_n   = {rx_sr[6:0], sda};
                  bit_cnt_n = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  bit_cnt_n = '0;
                  if (rx_sr[7:1] == SLAVE_ADDR) begin
                     state_n = ADDR_ACK;
                     oen_n   = 1'b0;
                     busy_n  = 1'b1;
                     rw_n    = rx_sr[0];
                  end else begin
                     state_n = IGNORE;
                  end
               end
            end

            ADDR_ACK: begin
               if (scl_rise && rw == RW_READ) begin
                  tx_sr_n     = {rd_data, IDLE_BYTE};
                  rd_strobe_n = 1'b1;
               end else if (scl_fall) begin
                  if (rw == RW_WRITE) begin
                     state_n    = RX_BYTE;
                     oen_n      = 1'b1;
                     byte_idx_n = '0;
                     bit_cnt_n  = '0;
                  end else begin
                     state_n   = TX_BYTE;
                     oen_n     = tx_sr[23];
                     tx_sr_n   = {tx_sr[22:0], 1'b1};
                     bit_cnt_n = 4'd1;
                  end
               end
            end

            RX_BYTE: begin
               if (scl_rise) begin
                  rx_sr_n   = {rx_sr[6:0], sda};
                  bit_cnt_n = bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7 && byte_idx == 2'd1) begin
                     wr_data_n  = {hi_byte, rx_sr[6:0], sda};
                     wr_valid_n = 1'b1;
                  end
               end else if (scl_fall && bit_cnt == 4'd8) begin
                  state_n   = RX_ACK;
                  bit_cnt_n = '0;
                  if (byte_idx == 2'd0) begin
                     hi_byte_n = rx_sr;
                  end
                  // Bytes beyond the second word byte are refused.
                  oen_n = byte_idx[1];
                  if (byte_idx != 2'd3) begin
                     byte_idx_n = byte_idx + 2'd1;
                  end
               end
            end

            RX_ACK: begin
               if (scl_fall) begin
                  state_n = RX_BYTE;
                  oen_n   = 1'b1;
               end
            end

            TX_BYTE: begin
               if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     state_n   = TX_ACK;
                     oen_n     = 1'b1;
                     bit_cnt_n = '0;
                  end else begin
                     oen_n     = tx_sr[23];
                     tx_sr_n   = {tx_sr[22:0], 1'b1};
                     bit_cnt_n = bit_cnt + 4'd1;
                  end
               end
            end

            TX_ACK: begin
               if (scl_rise && sda) begin
                  state_n = IGNORE;
               end else if (scl_fall) begin
                  state_n   = TX_BYTE;
                  oen_n     = tx_sr[23];
                  tx_sr_n   = {tx_sr[22:0], 1'b1};
                  bit_cnt_n = 4'd1;
               end
            end

            default: begin
            end
         endcase
      end
   end

   assign bus.sda_o   = 1'b0;
   assign bus.sda_oen = oen;

endmodule

// File: tb/tb_i2c_slave_word_port.sv
// Scoreboard bench for i2c_slave_word_port driven by a bit-level I2C master model.
module tb_i2c_slave_word_port;

   localparam int Q = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        m_scl, m_sda, scl_g, sda_g;
   logic        sda_line;
   logic [15:0] wr_data, rd_data;
   logic        wr_valid, rd_strobe, busy;

   int checks = 0;
   int failures = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int drive_cnt = 0;

   logic [15:0] exp_wr[$];
   logic [7:0]  exp_rd[$];

   i2c_slave_word_port_if bus ();

   assign sda_line  = m_sda & (bus.sda_oen | bus.sda_o);
   assign bus.scl_i = m_scl ^ scl_g;
   assign bus.sda_i = sda_line ^ sda_g;

   i2c_slave_word_port #(.SLAVE_ADDR(7'h2C), .FILTER_LEN(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .rd_data   (rd_data),
      .rd_strobe (rd_strobe),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SCL period; optional glitches on SCL (low phase) and SDA (high phase).
   task automatic clock_bit(input logic b, input logic glitch, output logic line);
      tick(Q);
      m_sda = b;
      if (glitch) begin
         tick(3); scl_g = 1'b1; tick(2); scl_g = 1'b0; tick(Q - 5);
      end else begin
         tick(Q);
      end
      m_scl = 1'b1;
      if (glitch) begin
         tick(Q / 2); sda_g = 1'b1; tick(2); sda_g = 1'b0; tick(Q / 2 - 2);
      end else begin
         tick(Q);
      end
      line = sda_line;
      tick(Q);
      m_scl = 1'b0;
   endtask

   task automatic bus_start();
      tick(Q); m_sda = 1'b1;
      tick(Q); m_scl = 1'b1;
      tick(Q); m_sda = 1'b0;
      tick(Q); m_scl = 1'b0;
   endtask

   task automatic bus_stop();
      tick(Q); m_sda = 1'b0;
      tick(Q); m_scl = 1'b1;
      tick(Q); m_sda = 1'b1;
      tick(2 * Q);
   endtask

   task automatic write_byte(input logic [7:0] v, input logic glitch, output logic ack);
      logic l;
      for (int i = 7; i >= 0; i--) clock_bit(v[i], glitch && (i == 4), l);
      clock_bit(1'b1, 1'b0, l);
      ack = ~l;
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] v);
      logic l;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, 1'b0, l);
         v[i] = l;
      end
      clock_bit(~ack, 1'b0, l);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b0) begin
            if (bus.sda_oen === 1'b0) drive_cnt++;
            if (wr_valid) begin
               wr_cnt++;
               if (exp_wr.size() > 0) check("wr_data_pulse", wr_data, exp_wr.pop_front());
               else check("wr_valid_unexpected", wr_valid, 1'b0);
            end
            if (rd_strobe) rd_cnt++;
            if (wr_valid || rd_strobe) check("wr_rd_overlap", wr_valid & rd_strobe, 1'b0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic       a;
      logic [7:0] v;
      int         w0, r0, d0;

      reset = 1'b1; m_scl = 1'b1; m_sda = 1'b1; scl_g = 1'b0; sda_g = 1'b0;
      rd_data = 16'h0000;
      tick(4);
      check("rst_sda_oen", bus.sda_oen, 1'b1);
      check("rst_wr_data", wr_data, 16'h0000);
      check("rst_wr_valid", wr_valid, 1'b0);
      check("rst_rd_strobe", rd_strobe, 1'b0);
      check("rst_busy", busy, 1'b0);
      reset = 1'b0;
      tick(10);

      // Word write 0xA55A
      w0 = wr_cnt;
      bus_start();
      write_byte(8'h58, 1'b0, a); check("t1_addr_ack", a, 1'b1);
      check("t1_busy", busy, 1'b1);
      exp_wr.push_back(16'hA55A);
      write_byte(8'hA5, 1'b0, a); check("t1_hi_ack", a, 1'b1);
      write_byte(8'h5A, 1'b0, a); check("t1_lo_ack", a, 1'b1);
      bus_stop();
      check("t1_wr_cnt", wr_cnt - w0, 1);
      check("t1_wr_data", wr_data, 16'hA55A);
      check("t1_busy_stop", busy, 1'b0);

      // Wrong address: never drives SDA
      w0 = wr_cnt; d0 = drive_cnt;
      bus_start();
      write_byte(8'h5A, 1'b0, a); check("t2_addr_nack", a, 1'b0);
      check("t2_busy", busy, 1'b0);
      write_byte(8'h3C, 1'b0, a); check("t2_data_nack", a, 1'b0);
      bus_stop();
      check("t2_drive_cnt", drive_cnt - d0, 0);
      check("t2_wr_cnt", wr_cnt - w0, 0);

      // Word read 0x1234, master ACK then NACK
      rd_data = 16'h1234; r0 = rd_cnt;
      bus_start();
      write_byte(8'h59, 1'b0, a); check("t3_addr_ack", a, 1'b1);
      exp_rd.push_back(8'h12); exp_rd.push_back(8'h34);
      read_byte(1'b1, v); check("t3_rd_hi", v, exp_rd.pop_front());
      read_byte(1'b0, v); check("t3_rd_lo", v, exp_rd.pop_front());
      bus_stop();
      check("t3_rd_cnt", rd_cnt - r0, 1);

      // Three data bytes: third refused
      w0 = wr_cnt;
      bus_start();
      write_byte(8'h58, 1'b0, a); check("t4_addr_ack", a, 1'b1);
      exp_wr.push_back(16'h1122);
      write_byte(8'h11, 1'b0, a); check("t4_b0_ack", a, 1'b1);
      write_byte(8'h22, 1'b0, a); check("t4_b1_ack", a, 1'b1);
      write_byte(8'h33, 1'b0, a); check("t4_b2_nack", a, 1'b0);
      bus_stop();
      check("t4_wr_cnt", wr_cnt - w0, 1);
      check("t4_wr_data", wr_data, 16'h1122);

      // One byte, repeated START, then a read
      w0 = wr_cnt; r0 = rd_cnt;
      bus_start();
      write_byte(8'h58, 1'b0, a); check("t5_addr_ack", a, 1'b1);
      write_byte(8'hBE, 1'b0, a); check("t5_b0_ack", a, 1'b1);
      rd_data = 16'hC3A7;
      bus_start();
      write_byte(8'h59, 1'b0, a); check("t5_raddr_ack", a, 1'b1);
      exp_rd.push_back(8'hC3); exp_rd.push_back(8'hA7);
      read_byte(1'b1, v); check("t5_rd_hi", v, exp_rd.pop_front());
      read_byte(1'b0, v); check("t5_rd_lo", v, exp_rd.pop_front());
      bus_stop();
      check("t5_wr_cnt", wr_cnt - w0, 0);
      check("t5_rd_cnt", rd_cnt - r0, 1);
      check("t5_wr_data", wr_data, 16'h1122);

      // STOP after a single data byte
      w0 = wr_cnt;
      bus_start();
      write_byte(8'h58, 1'b0, a); check("t6_addr_ack", a, 1'b1);
      write_byte(8'h77, 1'b0, a); check("t6_b0_ack", a, 1'b1);
      bus_stop();
      check("t6_wr_cnt", wr_cnt - w0, 0);
      check("t6_wr_data", wr_data, 16'h1122);

      // Reset while the address ACK is driven low
      bus_start();
      for (int i = 7; i >= 0; i--) begin
         v = 8'h58;
         clock_bit(v[i], 1'b0, a);
      end
      tick(12);
      check("t7_ack_drive", bus.sda_oen, 1'b0);
      check("t7_busy_pre", busy, 1'b1);
      reset = 1'b1;
      tick(1);
      check("t7_rst_oen", bus.sda_oen, 1'b1);
      check("t7_rst_wr_data", wr_data, 16'h0000);
      check("t7_rst_busy", busy, 1'b0);
      reset = 1'b0;
      tick(8);
      m_scl = 1'b1; tick(Q); m_scl = 1'b0;
      bus_stop();

      // Short glitches on SCL and SDA during data bytes
      w0 = wr_cnt;
      bus_start();
      write_byte(8'h58, 1'b0, a); check("t8_addr_ack", a, 1'b1);
      exp_wr.push_back(16'h5AC3);
      write_byte(8'h5A, 1'b1, a); check("t8_hi_ack", a, 1'b1);
      write_byte(8'hC3, 1'b1, a); check("t8_lo_ack", a, 1'b1);
      bus_stop();
      check("t8_wr_cnt", wr_cnt - w0, 1);
      check("t8_wr_data", wr_data, 16'h5AC3);

      check("exp_wr_drained", exp_wr.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_slave_word_port.md
Name: i2c_slave_word_port

Overview:
- I2C target (responder) at a fixed 7-bit address. It is the far-end counterpart of the team's I2C word-write master, which sends START, ADDR+W, DATA_H, DATA_L, STOP.
- Accepts 16-bit word writes, MSB byte first, and serves 16-bit word reads.
- Used on board-level bench models and as an FPGA-side control endpoint.
- Open-drain only: the block drives SDA low or releases it; it never drives SCL (no clock stretching).

Parameters:
- SLAVE_ADDR, 7'h2C, 7-bit address the block answers to.
- FILTER_LEN, 3, consecutive identical synchronized samples needed to accept a new SCL/SDA level.

Ports:
- clk  in  1  system clock, at least 20x the SCL frequency.
- reset  in  1  synchronous, active-high reset.
- scl_i  in  1  SCL line input, asynchronous.
- sda_i  in  1  SDA line input, asynchronous.
- sda_o  out  1  SDA output value, constant 1'b0.
- sda_oen  out  1  SDA output enable, active low: 0 pulls SDA low.
- wr_data  out  16  last word received; held until the next write completes.
- wr_valid  out  1  one-cycle pulse when wr_data updates.
- rd_data  in  16  word returned on reads; sampled when ADDR+R is acknowledged.
- rd_strobe  out  1  one-cycle pulse when rd_data is sampled.
- busy  out  1  high from an addressed START (address match) until STOP.

Behaviour:
- Reset values:
  - sda_oen=1, wr_data=0, wr_valid=0, rd_strobe=0, busy=0.
  - State IDLE; filters preset to 1.
- Input conditioning:
  - 2-FF synchronizer on each line, then a FILTER_LEN-sample majority/hold filter.
  - Edge detectors on filtered SCL and SDA.
  - Input-to-decision latency: 2+FILTER_LEN clocks.
- Bus conditions (filtered signals):
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - Both override any state.
  - START (including repeated START) -> ADDR, bit counter=0, SDA released.
  - STOP -> IDLE, SDA released, busy=0.
- Sampling and driving:
  - Data bits are sampled on the SCL rising edge.
  - sda_oen changes only on the SCL falling edge, one clock after its detection.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first. On the 8th falling edge:
    - addr[7:1]==SLAVE_ADDR -> ADDR_ACK (drive SDA low); busy=1.
    - Mismatch -> IGNORE: never drive, wait for STOP/START.
  - ADDR_ACK: on the falling edge ending the ACK bit:
    - R/W=0 -> RX_BYTE, byte index=0; release SDA.
    - R/W=1 -> TX_BYTE. Latch rd_data into the shift register and pulse rd_strobe on the ACK rising edge. Drive bit 15 on the same falling edge.
  - RX_BYTE: shift 8 bits.
    - Byte index 0 -> hold as high byte; ACK.
    - Byte index 1 -> wr_data={high, low}; wr_valid pulses on the 8th SCL rising edge; ACK.
    - Byte index 2 or more -> NACK (release SDA); wr_data unchanged.
    - RX_ACK leads back to RX_BYTE.
  - TX_BYTE: drive the shift-register MSB on each falling edge (1 = release SDA). Release SDA after the 8th bit, then go to TX_ACK.
  - TX_ACK: sample master ACK on the rising edge.
    - ACK after the high byte -> send the low byte.
    - ACK after the low byte -> send 8'hFF (released bus).
    - NACK -> IGNORE until STOP/START.
- Boundaries:
  - STOP after only one data byte: no wr_valid; wr_data unchanged.
  - Repeated START mid-byte: partial byte discarded.
  - reset mid-transfer: SDA released within 1 clock; wr_data returns to 0.
  - wr_valid and rd_strobe are never asserted in the same cycle.
  - A glitch shorter than FILTER_LEN clocks on either line has no effect.

Decomposition:
- Package i2c_slave_pkg:
  - State enum (IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE).
  - Constants RW_WRITE=0, RW_READ=1, IDLE_BYTE=8'hFF.
- Sub-module i2c_line_filter: synchronizer, filter and rise/fall detect. Instantiated twice, for SCL and SDA.

Test Plan:
- Write addr 0x2C, data 0xA55A, STOP -> ACK on all 3 bytes; wr_valid pulses once; wr_data=16'hA55A; busy drops at STOP.
- Write addr 0x2D -> no SDA drive at any time (addr NACK seen by master); wr_valid never asserted; busy stays 0.
- Read addr 0x2C with rd_data=16'h1234, master ACK then NACK -> bytes 0x12, 0x34 seen on SDA; rd_strobe pulses once.
- Write 0x2C + 3 bytes 0x11, 0x22, 0x33 -> first two ACKed, third NACKed; wr_data=16'h1122.
- Write 0x2C, 0xBE, repeated START, read 0x2C -> no wr_valid; read proceeds normally with current rd_data.
- Assert reset while the block drives the ACK low -> sda_oen=1 on the next clock; 2-clock SCL glitch during a byte leaves the received data unaffected.
